// File: rtl/hit_judge.sv
// hit_judge: queues arrow patterns as in-flight notes, ages them toward the
// target line and judges each player's pad presses against the oldest note.
// Optional feature: define HIT_JUDGE_MISS_EN to build the miss_a/miss_b pulse logic;
// without it both miss outputs are tied low.
module hit_judge #(
    parameter int FIFO_DEPTH    = 4,
    parameter int TRAVEL_CYCLES = 50_000_000,
    parameter int WINDOW_CYCLES = 5_000_000
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          pattern_valid,
    input  logic [7:0]                    pattern_out,
    input  logic [3:0]                    player_a_keys,
    input  logic [3:0]                    player_b_keys,
    input  logic                          game_over,
    output logic                          perfect_hit_a,
    output logic                          perfect_hit_b,
    output logic                          miss_a,
    output logic                          miss_b,
    output logic                          head_valid,
    output logic [7:0]                    head_pattern,
    output logic [$clog2(FIFO_DEPTH):0]   notes_count,
    output logic                          overflow
);

    localparam int AW = $clog2(TRAVEL_CYCLES + WINDOW_CYCLES + 2);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [AW-1:0] WIN_LO     = AW'(TRAVEL_CYCLES - WINDOW_CYCLES);
    localparam logic [AW-1:0] EXPIRE_AGE = AW'(TRAVEL_CYCLES + WINDOW_CYCLES + 1);
    localparam logic [AW-1:0] AGE_MAX    = {AW{1'b1}};

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_APPROACH,
        ST_WINDOW,
        ST_RETIRE
    } head_state_t;

    // Note storage: remaining lanes and age per slot, circular buffer.
    logic [7:0]    lanes [FIFO_DEPTH];
    logic [AW-1:0] age   [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic [3:0]    keys_a_q;
    logic [3:0]    keys_b_q;

    logic [7:0]    head_lanes;
    logic [AW-1:0] head_age;
    head_state_t   head_state;
    logic [3:0]    edge_a;
    logic [3:0]    edge_b;
    logic          hit_a;
    logic          hit_b;
    logic          pop;
    logic          full;
    logic          push_req;
    logic          push_ok;
    logic          drop;

    assign head_lanes   = lanes[rd_ptr];
    assign head_age     = age[rd_ptr];
    assign head_valid   = (count != '0);
    assign head_pattern = head_valid ? head_lanes : 8'h00;
    assign notes_count  = count;

    // Phase of the head note: a note with no lanes left or past the window retires.
    always_comb begin
        head_state = ST_EMPTY;
        if (count != '0) begin
            if ((head_lanes == 8'h00) || (head_age >= EXPIRE_AGE)) begin
                head_state = ST_RETIRE;
            end else if (head_age < WIN_LO) begin
                head_state = ST_APPROACH;
            end else begin
                head_state = ST_WINDOW;
            end
        end
    end

    // Rising-edge press detection and per-player judgement against the head note.
    always_comb begin
        edge_a   = player_a_keys & ~keys_a_q;
        edge_b   = player_b_keys & ~keys_b_q;
        hit_a    = !game_over && (head_state == ST_WINDOW) && ((edge_a & head_lanes[3:0]) != 4'h0);
        hit_b    = !game_over && (head_state == ST_WINDOW) && ((edge_b & head_lanes[7:4]) != 4'h0);
        pop      = !game_over && (head_state == ST_RETIRE);
        full     = (count == CW'(FIFO_DEPTH));
        push_req = pattern_valid && (pattern_out != 8'h00) && !game_over;
        push_ok  = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    // Queue, ageing, key history, hit pulses and sticky overflow.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                lanes[i] <= 8'h00;
                age[i]   <= '0;
            end
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            keys_a_q      <= 4'h0;
            keys_b_q      <= 4'h0;
            perfect_hit_a <= 1'b0;
            perfect_hit_b <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            keys_a_q      <= player_a_keys;
            keys_b_q      <= player_b_keys;
            perfect_hit_a <= hit_a;
            perfect_hit_b <= hit_b;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (age[i] != AGE_MAX) begin
                    age[i] <= age[i] + AW'(1);
                end
            end
            if (game_over) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (hit_a) begin
                    lanes[rd_ptr][3:0] <= 4'h0;
                end
                if (hit_b) begin
                    lanes[rd_ptr][7:4] <= 4'h0;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (push_ok) begin
                    lanes[wr_ptr] <= pattern_out;
                    age[wr_ptr]   <= '0;
                    wr_ptr        <= wr_ptr + PW'(1);
                end
                case ({push_ok, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
                if (drop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

`ifdef HIT_JUDGE_MISS_EN
    logic expire;
    logic miss_a_now;
    logic miss_b_now;

    always_comb begin
        expire     = pop && (head_age >= EXPIRE_AGE);
        miss_a_now = !game_over && (((edge_a != 4'h0) && !hit_a) || (expire && (head_lanes[3:0] != 4'h0)));
        miss_b_now = !game_over && (((edge_b != 4'h0) && !hit_b) || (expire && (head_lanes[7:4] != 4'h0)));
    end

    // Miss pulses: stray/early/late presses or a note expiring with lanes left.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            miss_a <= 1'b0;
            miss_b <= 1'b0;
        end else begin
            miss_a <= miss_a_now;
            miss_b <= miss_b_now;
        end
    end
`else
    assign miss_a = 1'b0;
    assign miss_b = 1'b0;
`endif

endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge: directed stimulus for hit_judge with a scoreboard of expected
// hit/miss pulses keyed by the cycle in which they must appear.
module tb_hit_judge;

    localparam int DEPTH  = 4;
    localparam int TRAVEL = 20;
    localparam int WINDOW = 2;

`ifdef HIT_JUDGE_MISS_EN
    localparam bit MISS_EN = 1'b1;
`else
    localparam bit MISS_EN = 1'b0;
`endif

    typedef struct {
        int due;
        bit ha;
        bit hb;
        bit ma;
        bit mb;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pattern_valid = 1'b0;
    logic [7:0] pattern_out = 8'h00;
    logic [3:0] player_a_keys = 4'h0;
    logic [3:0] player_b_keys = 4'h0;
    logic       game_over = 1'b0;
    logic       perfect_hit_a;
    logic       perfect_hit_b;
    logic       miss_a;
    logic       miss_b;
    logic       head_valid;
    logic [7:0] head_pattern;
    logic [2:0] notes_count;
    logic       overflow;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    hit_judge #(
        .FIFO_DEPTH   (DEPTH),
        .TRAVEL_CYCLES(TRAVEL),
        .WINDOW_CYCLES(WINDOW)
    ) dut (
        .CLOCK_50     (clk),
        .reset        (reset),
        .pattern_valid(pattern_valid),
        .pattern_out  (pattern_out),
        .player_a_keys(player_a_keys),
        .player_b_keys(player_b_keys),
        .game_over    (game_over),
        .perfect_hit_a(perfect_hit_a),
        .perfect_hit_b(perfect_hit_b),
        .miss_a       (miss_a),
        .miss_b       (miss_b),
        .head_valid   (head_valid),
        .head_pattern (head_pattern),
        .notes_count  (notes_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic expectEvent(input int due, input bit ha, input bit hb, input bit ma, input bit mb);
        exp_t e;
        e.due = due;
        e.ha  = ha;
        e.hb  = hb;
        e.ma  = ma & MISS_EN;
        e.mb  = mb & MISS_EN;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic waitCycle(input int target);
        if (cyc > target) begin
            checkOutput("schedule", cyc, target);
        end
        while (cyc < target) step();
    endtask

    // Drives one pattern for a single cycle and returns the cycle it was driven in.
    task automatic applyStimulus(input logic [7:0] pattern, output int pc);
        pattern_valid = 1'b1;
        pattern_out   = pattern;
        pc            = cyc;
        step();
        pattern_valid = 1'b0;
        pattern_out   = 8'h00;
    endtask

    task automatic doReset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Scoreboard: every cycle the pulse outputs must match what is due now (default quiet).
    always @(negedge clk) begin
        bit eha, ehb, ema, emb;
        eha = 0; ehb = 0; ema = 0; emb = 0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].due == cyc) begin
                eha |= exp_q[i].ha;
                ehb |= exp_q[i].hb;
                ema |= exp_q[i].ma;
                emb |= exp_q[i].mb;
                exp_q.delete(i);
            end
        end
        checkOutput("perfect_hit_a", perfect_hit_a, eha);
        checkOutput("perfect_hit_b", perfect_hit_b, ehb);
        checkOutput("miss_a", miss_a, ema);
        checkOutput("miss_b", miss_b, emb);
    end

    initial begin
        int pc;
        int c0;

        // Reset state
        step();
        doReset();
        checkOutput("rst_head_valid", head_valid, 1'b0);
        checkOutput("rst_count", notes_count, 3'd0);
        checkOutput("rst_overflow", overflow, 1'b0);
        checkOutput("rst_head_pattern", head_pattern, 8'h00);

        // Hit on target: push 01, A lane0 at age 20
        applyStimulus(8'h01, pc);
        checkOutput("t1_count", notes_count, 3'd1);
        checkOutput("t1_head", head_pattern, 8'h01);
        waitCycle(pc + 21);
        player_a_keys = 4'h1;
        expectEvent(cyc + 1, 1, 0, 0, 0);
        step();
        checkOutput("t1_cleared", head_pattern, 8'h00);
        checkOutput("t1_count_before_pop", notes_count, 3'd1);
        player_a_keys = 4'h0;
        step();
        checkOutput("t1_count_after_pop", notes_count, 3'd0);

        // Early press held through window, then expiry at age 23
        applyStimulus(8'h02, pc);
        expectEvent(pc + 25, 0, 0, 1, 0);
        waitCycle(pc + 16);
        player_a_keys = 4'h2;
        expectEvent(cyc + 1, 0, 0, 1, 0);
        waitCycle(pc + 24);
        checkOutput("t2_count_at_expiry", notes_count, 3'd1);
        step();
        checkOutput("t2_count_after_expiry", notes_count, 3'd0);
        player_a_keys = 4'h0;
        step();

        // Overflow: five consecutive pushes into a four-deep queue
        c0 = cyc;
        for (int i = 0; i < 5; i++) begin
            pattern_valid = 1'b1;
            pattern_out   = 8'h01 << i;
            if (i < 4) expectEvent(c0 + i + 25, 0, 0, 1, 0);
            step();
        end
        pattern_valid = 1'b0;
        pattern_out   = 8'h00;
        checkOutput("t3_count_full", notes_count, 3'd4);
        checkOutput("t3_overflow", overflow, 1'b1);
        checkOutput("t3_head", head_pattern, 8'h01);
        waitCycle(c0 + 25);
        checkOutput("t3_second_head", head_pattern, 8'h02);
        waitCycle(c0 + 28);
        checkOutput("t3_head_valid_drained", head_valid, 1'b0);
        checkOutput("t3_overflow_held", overflow, 1'b1);
        doReset();
        checkOutput("t3_overflow_reset", overflow, 1'b0);

        // Both players hit in the same cycle at age 19
        applyStimulus(8'h21, pc);
        waitCycle(pc + 20);
        player_a_keys = 4'h1;
        player_b_keys = 4'h2;
        expectEvent(cyc + 1, 1, 1, 0, 0);
        step();
        checkOutput("t4_cleared", head_pattern, 8'h00);
        player_a_keys = 4'h0;
        player_b_keys = 4'h0;
        step();
        checkOutput("t4_count", notes_count, 3'd0);

        // Early press (age 17) is no hit; second press at age 22 hits
        applyStimulus(8'h04, pc);
        waitCycle(pc + 18);
        player_a_keys = 4'h4;
        expectEvent(cyc + 1, 0, 0, 1, 0);
        step();
        player_a_keys = 4'h0;
        checkOutput("t5_head_kept", head_pattern, 8'h04);
        waitCycle(pc + 23);
        player_a_keys = 4'h4;
        expectEvent(cyc + 1, 1, 0, 0, 0);
        step();
        player_a_keys = 4'h0;
        step();
        checkOutput("t5_count", notes_count, 3'd0);

        // game_over flushes and freezes judging
        applyStimulus(8'h11, pc);
        waitCycle(pc + 11);
        game_over = 1'b1;
        step();
        checkOutput("t6_count_flushed", notes_count, 3'd0);
        checkOutput("t6_head_valid", head_valid, 1'b0);
        player_a_keys = 4'h1;
        player_b_keys = 4'h1;
        applyStimulus(8'h11, pc);
        step();
        checkOutput("t6_no_push", notes_count, 3'd0);
        game_over     = 1'b0;
        player_a_keys = 4'h0;
        player_b_keys = 4'h0;
        step();

        // Zero pattern ignored; 03 hit on lane1 at age 21
        applyStimulus(8'h00, pc);
        checkOutput("t7_zero_ignored", head_valid, 1'b0);
        applyStimulus(8'h03, pc);
        waitCycle(pc + 22);
        player_a_keys = 4'h2;
        expectEvent(cyc + 1, 1, 0, 0, 0);
        step();
        checkOutput("t7_cleared", head_pattern, 8'h00);
        checkOutput("t7_count_before_pop", notes_count, 3'd1);
        player_a_keys = 4'h0;
        step();
        checkOutput("t7_count_after_pop", notes_count, 3'd0);

        step();
        step();
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
